cursor_mover: RTL and testbench
===============================

# cursor_mover

Parametrised successor to the single-step cursor mover in the paint datapath. It owns the cursor X/Y registers and moves them on frame ticks from the 4-bit direction pad. It adds press-then-auto-repeat timing, edge clamp or wrap-around, and optional acceleration. It feeds the drawing FSM and the VGA cursor overlay, and replaces the external position feedback loop.

## Interface
- X_W, 9: X coordinate width
- Y_W, 9: Y coordinate width
- X_MAX, 319: largest legal X
- Y_MAX, 239: largest legal Y
- X_INIT, 160: X after reset
- Y_INIT, 120: Y after reset
- WRAP, 0: 0 = clamp at edges, 1 = wrap modulo (MAX+1)
- REPEAT_DELAY, 8: ticks from first move to first auto-repeat (≥1)
- REPEAT_PERIOD, 2: ticks between auto-repeats (≥1)
- ACCEL_AFTER, 8: repeat moves before fast step engages
- STEP_FAST, 4: fast step size (1..X_MAX, 1..Y_MAX)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle movement enable (frame rate)
- directions  in  4  bit3 left, bit2 up, bit1 right, bit0 down
- load  in  1  force position to load_x/load_y
- load_x  in  X_W  load X value
- load_y  in  Y_W  load Y value
- x  out  X_W  cursor X
- y  out  Y_W  cursor Y
- moved  out  1  one-cycle pulse: x/y changed this cycle
- fast  out  1  fast step active

## Operation
- Effective direction: left beats right, up beats down. Diagonal moves are allowed. dir_eff = 0 means nothing is held.
- States:
  - IDLE: on a tick with dir_eff≠0, move, latch held_dir, cnt←REPEAT_DELAY, go to DELAY.
  - DELAY: on a tick, if cnt==1, move, cnt←REPEAT_PERIOD, go to REPEAT; otherwise cnt−1.
  - REPEAT: on a tick, if cnt==1, move, reload cnt, rep+1 (saturating); otherwise cnt−1.
- In DELAY or REPEAT, a tick with dir_eff==0 goes to IDLE with no move and clears rep and fast.
- In DELAY or REPEAT, a tick with dir_eff≠held_dir counts as a fresh press: move immediately, re-latch held_dir, cnt←REPEAT_DELAY, go to DELAY, clear rep and fast.
- Non-tick cycles change nothing except on load or reset.
- Step size is 1, or STEP_FAST when fast=1. fast sets when rep reaches ACCEL_AFTER.
- Per-axis arithmetic is done at width W+1.
  - Clamp: x−s < 0 gives 0; x+s > MAX gives MAX.
  - Wrap: results below 0 add MAX+1; results above MAX subtract MAX+1.
- A move that leaves both axes unchanged (clamped at the edge) does not pulse moved.
- load has priority over reset-free movement. It sets x←min(load_x, X_MAX) and y←min(load_y, Y_MAX), forces IDLE, clears rep and fast, and pulses moved only if the value changed. Any move in the same cycle is discarded.

## Timing
- Reset: x=X_INIT, y=Y_INIT, moved=0, fast=0, state IDLE, cnt=0, rep=0. Reset wins over load and tick.
- A move is registered: x/y/moved update on the clock edge of the tick cycle. Latency is 1 clock.
- Holding a key from tick T0 gives moves at T0, T0+REPEAT_DELAY, then every REPEAT_PERIOD ticks.
- Reset mid-hold: the next tick after reset deasserts is treated as a new press if directions are still held.

## Configuration
- CURSOR_ACCEL_EN defined: rep counter, fast output and STEP_FAST stepping are present as described.
- CURSOR_ACCEL_EN undefined: step is always 1, fast is tied to 0, the rep counter is removed, and ACCEL_AFTER and STEP_FAST are ignored.

## Structure
- paint_pkg holds:
  - direction bit indices DIR_LEFT=3, DIR_UP=2, DIR_RIGHT=1, DIR_DOWN=0
  - the state enum (IDLE, DELAY, REPEAT)
  - a dir_eff priority function
- Sub-module axis_step, instantiated twice, is combinational: pos, MAX, step, dec, inc and WRAP give next_pos. The FSM, counters and registers live in cursor_mover.

## Test plan
- Reset with X_INIT=160, Y_INIT=120, then one tick with directions=4'b1000: x=159, y=120, moved pulses one cycle.
- Hold right for 12 ticks with DELAY=8, PERIOD=2: moves at ticks 0, 8 and 10 only, ending at x=163.
- Clamp: x=0, hold left 3 ticks gives x=0 and moved=0. With WRAP=1, x=0 and one left tick gives x=319.
- Both left and right plus both up and down held at (10,10) for one tick gives (9,9). Switching from left to down mid-DELAY moves y at once and restarts the delay.
- Accel: hold right past 8 repeats; the next repeat step is 4 and fast=1. Release gives fast=0 and the next press steps 1. With CURSOR_ACCEL_EN undefined, the step stays 1.
- load in the same cycle as a tick with load_x=400 and load_y=50 gives x=319, y=50, state IDLE. Reset in the same cycle as load gives (160,120).

Source files
------------

// File: rtl/paint_pkg.sv
// Shared definitions for the paint cursor datapath: direction bit indices,
// cursor FSM states and the direction priority resolver.
package paint_pkg;

  localparam int DIR_LEFT  = 3;
  localparam int DIR_UP    = 2;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Left beats right, up beats down; diagonals pass through.
  function automatic logic [3:0] dir_eff(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[DIR_LEFT]) r[DIR_RIGHT] = 1'b0;
    if (d[DIR_UP])   r[DIR_DOWN]  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/cursor_mover_if.sv
// Pad/load inputs and cursor position outputs of cursor_mover.
interface cursor_mover_if #(
  parameter int X_W = 9,
  parameter int Y_W = 9
);
  logic           tick;
  logic [3:0]     directions;
  logic           load;
  logic [X_W-1:0] load_x;
  logic [Y_W-1:0] load_y;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           moved;
  logic           fast;

  modport master (
    output tick, directions, load, load_x, load_y,
    input  x, y, moved, fast
  );

  modport slave (
    input  tick, directions, load, load_x, load_y,
    output x, y, moved, fast
  );
endinterface

// File: rtl/cursor_mover_axis_step.sv
// Combinational one-axis step: decrement/increment pos by step, then clamp
// to [0, MAX] or wrap modulo MAX+1. Arithmetic is carried at W+1 bits.
module axis_step #(
  parameter int W    = 9,
  parameter int MAX  = 319,
  parameter int WRAP = 0
) (
  input  logic [W-1:0] pos,
  input  logic [W-1:0] step,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] next_pos
);
  localparam logic [W:0] MAX_W = (W+1)'(MAX);
  localparam logic [W:0] MOD_W = (W+1)'(MAX + 1);

  logic [W:0] lo;
  logic [W:0] hi;
  logic [W:0] lo_wrap;
  logic [W:0] hi_wrap;

  always_comb begin
    lo       = {1'b0, pos} - {1'b0, step};
    hi       = {1'b0, pos} + {1'b0, step};
    lo_wrap  = lo + MOD_W;
    hi_wrap  = hi - MOD_W;
    next_pos = pos;
    if (dec) begin
      // lo[W] set means the result went below zero
      if (lo[W]) next_pos = (WRAP != 0) ? lo_wrap[W-1:0] : '0;
      else       next_pos = lo[W-1:0];
    end else if (inc) begin
      if (hi > MAX_W) next_pos = (WRAP != 0) ? hi_wrap[W-1:0] : MAX_W[W-1:0];
      else            next_pos = hi[W-1:0];
    end
  end
endmodule

// File: rtl/cursor_mover.sv
// Cursor X/Y registers moved from the direction pad on frame ticks, with
// press/auto-repeat timing. Build macro CURSOR_ACCEL_EN enables acceleration.
//
// state  | meaning
// IDLE   | nothing held; next tick with a direction is a fresh press
// DELAY  | first move done, counting down to the first auto-repeat
// REPEAT | auto-repeating every REPEAT_PERIOD ticks
module cursor_mover
  import paint_pkg::*;
#(
  parameter int X_W           = 9,
  parameter int Y_W           = 9,
  parameter int X_MAX         = 319,
  parameter int Y_MAX         = 239,
  parameter int X_INIT        = 160,
  parameter int Y_INIT        = 120,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 2,
  parameter int ACCEL_AFTER   = 8,
  parameter int STEP_FAST     = 4
) (
  input logic            clock,
  input logic            reset,
  cursor_mover_if.slave  bus
);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       held, held_n;
  logic [3:0]       dir;
  logic             do_move;
  logic             fresh;
  logic             use_fast;

  logic [X_W-1:0]   x_q, nx, ld_x, step_x;
  logic [Y_W-1:0]   y_q, ny, ld_y, step_y;
  logic             moved_q;

`ifdef CURSOR_ACCEL_EN
  localparam int REP_W = $clog2(ACCEL_AFTER + 1);
  logic [REP_W-1:0] rep, rep_n;
  logic             fast_q, fast_n;
`endif

  always_comb begin
    dir     = dir_eff(bus.directions);
    state_n = state;
    cnt_n   = cnt;
    held_n  = held;
    do_move = 1'b0;
    fresh   = 1'b0;
`ifdef CURSOR_ACCEL_EN
    rep_n   = rep;
    fast_n  = fast_q;
`endif
    if (bus.tick) begin
      case (state)
        IDLE: begin
          if (dir != 4'b0000) fresh = 1'b1;
        end
        default: begin
          if (dir == 4'b0000) begin
            state_n = IDLE;
`ifdef CURSOR_ACCEL_EN
            rep_n   = '0;
            fast_n  = 1'b0;
`endif
          end else if (dir != held) begin
            fresh = 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            do_move = 1'b1;
            cnt_n   = CNT_W'(REPEAT_PERIOD);
            state_n = REPEAT;
`ifdef CURSOR_ACCEL_EN
            if (state == REPEAT) begin
              if (rep != REP_W'(ACCEL_AFTER)) rep_n = rep + REP_W'(1);
              if (rep_n == REP_W'(ACCEL_AFTER)) fast_n = 1'b1;
            end
`endif
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
      endcase
      if (fresh) begin
        do_move = 1'b1;
        held_n  = dir;
        cnt_n   = CNT_W'(REPEAT_DELAY);
        state_n = DELAY;
`ifdef CURSOR_ACCEL_EN
        rep_n   = '0;
        fast_n  = 1'b0;
`endif
      end
    end
    if (bus.load) begin
      state_n = IDLE;
`ifdef CURSOR_ACCEL_EN
      rep_n   = '0;
      fast_n  = 1'b0;
`endif
    end
  end

  // A fresh press always steps by one, even if fast was set before it.
`ifdef CURSOR_ACCEL_EN
  assign use_fast = fast_q & ~fresh;
  assign step_x   = use_fast ? X_W'(STEP_FAST) : X_W'(1);
  assign step_y   = use_fast ? Y_W'(STEP_FAST) : Y_W'(1);
  assign bus.fast = fast_q;
`else
  assign use_fast = 1'b0;
  assign step_x   = X_W'(1);
  assign step_y   = Y_W'(1);
  assign bus.fast = 1'b0;
`endif

  axis_step #(.W(X_W), .MAX(X_MAX), .WRAP(WRAP)) u_step_x (
    .pos      (x_q),
    .step     (step_x),
    .dec      (dir[DIR_LEFT]),
    .inc      (dir[DIR_RIGHT]),
    .next_pos (nx)
  );

  axis_step #(.W(Y_W), .MAX(Y_MAX), .WRAP(WRAP)) u_step_y (
    .pos      (y_q),
    .step     (step_y),
    .dec      (dir[DIR_UP]),
    .inc      (dir[DIR_DOWN]),
    .next_pos (ny)
  );

  assign ld_x = (bus.load_x > X_W'(X_MAX)) ? X_W'(X_MAX) : bus.load_x;
  assign ld_y = (bus.load_y > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : bus.load_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      held  <= '0;
`ifdef CURSOR_ACCEL_EN
      rep    <= '0;
      fast_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      held  <= held_n;
`ifdef CURSOR_ACCEL_EN
      rep    <= rep_n;
      fast_q <= fast_n;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= X_W'(X_INIT);
      y_q     <= Y_W'(Y_INIT);
      moved_q <= 1'b0;
    end else if (bus.load) begin
      x_q     <= ld_x;
      y_q     <= ld_y;
      moved_q <= (ld_x != x_q) || (ld_y != y_q);
    end else if (do_move) begin
      x_q     <= nx;
      y_q     <= ny;
      moved_q <= (nx != x_q) || (ny != y_q);
    end else begin
      moved_q <= 1'b0;
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.moved = moved_q;

endmodule

// File: tb/tb_cursor_mover.sv
// Scoreboard bench for cursor_mover: a clamp instance and a wrap instance.
// Expected moves are queued by the stimulus and popped on each moved pulse.
module tb_cursor_mover;

  typedef struct {
    int x;
    int y;
    bit f;
  } exp_t;

  logic clock;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  exp_t q0[$];
  exp_t q1[$];

  cursor_mover_if #(.X_W(9), .Y_W(9)) if0 ();
  cursor_mover_if #(.X_W(9), .Y_W(9)) if1 ();

  cursor_mover #(.WRAP(0)) dut0 (.clock(clock), .reset(reset), .bus(if0));
  cursor_mover #(.WRAP(1)) dut1 (.clock(clock), .reset(reset), .bus(if1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int sel, input int ex, input int ey, input bit ef);
    exp_t e;
    e.x = ex; e.y = ey; e.f = ef;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // One tick cycle; directions remain held afterwards.
  task automatic tk(input int sel, input logic [3:0] d);
    @(negedge clock);
    if (sel == 0) begin if0.tick = 1'b1; if0.directions = d; end
    else          begin if1.tick = 1'b1; if1.directions = d; end
    @(negedge clock);
    if0.tick = 1'b0;
    if1.tick = 1'b0;
  endtask

  task automatic ld(input int sel, input int lx, input int ly, input bit with_tick, input logic [3:0] d);
    @(negedge clock);
    if (sel == 0) begin
      if0.load = 1'b1; if0.load_x = 9'(lx); if0.load_y = 9'(ly);
      if0.tick = with_tick; if0.directions = d;
    end else begin
      if1.load = 1'b1; if1.load_x = 9'(lx); if1.load_y = 9'(ly);
      if1.tick = with_tick; if1.directions = d;
    end
    @(negedge clock);
    if0.load = 1'b0; if1.load = 1'b0;
    if0.tick = 1'b0; if1.tick = 1'b0;
  endtask

  // Monitor: every moved pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (if0.moved) begin
      total++;
      if (q0.size() == 0) begin
        $display("FAIL dut0_unexpected_move: got x=%0d y=%0d expected no move", if0.x, if0.y);
      end else begin
        e = q0.pop_front();
        if (int'(if0.x) == e.x && int'(if0.y) == e.y && if0.fast == e.f) passed++;
        else $display("FAIL dut0_move: got (%0d,%0d,fast=%0b) expected (%0d,%0d,fast=%0b)",
                      if0.x, if0.y, if0.fast, e.x, e.y, e.f);
      end
    end
    if (if1.moved) begin
      total++;
      if (q1.size() == 0) begin
        $display("FAIL dut1_unexpected_move: got x=%0d y=%0d expected no move", if1.x, if1.y);
      end else begin
        e = q1.pop_front();
        if (int'(if1.x) == e.x && int'(if1.y) == e.y) passed++;
        else $display("FAIL dut1_move: got (%0d,%0d) expected (%0d,%0d)", if1.x, if1.y, e.x, e.y);
      end
    end
  end

  initial begin
    int  ax;
    int  rep;
    bit  f;
    bit  mv;
    reset = 1'b1;
    if0.tick = 1'b0; if0.directions = 4'b0; if0.load = 1'b0; if0.load_x = '0; if0.load_y = '0;
    if1.tick = 1'b0; if1.directions = 4'b0; if1.load = 1'b0; if1.load_x = '0; if1.load_y = '0;
    repeat (3) @(negedge clock);
    chk("reset_x", int'(if0.x), 160);
    chk("reset_y", int'(if0.y), 120);
    chk("reset_moved", int'(if0.moved), 0);
    chk("reset_fast", int'(if0.fast), 0);
    reset = 1'b0;

    // single left tick
    push(0, 159, 120, 0);
    tk(0, 4'b1000);
    tk(0, 4'b0000);

    // hold right 12 ticks from 160: moves at ticks 0, 8, 10
    push(0, 160, 120, 0);
    ld(0, 160, 120, 0, 4'b0000);
    ax = 160;
    for (int t = 0; t < 12; t++) begin
      if (t == 0 || t == 8 || t == 10) begin ax++; push(0, ax, 120, 0); end
      tk(0, 4'b0010);
    end
    chk("hold_right_x", int'(if0.x), 163);
    tk(0, 4'b0000);

    // clamp at left edge
    push(0, 0, 120, 0);
    ld(0, 0, 120, 0, 4'b0000);
    for (int t = 0; t < 3; t++) tk(0, 4'b1000);
    chk("clamp_x", int'(if0.x), 0);
    tk(0, 4'b0000);

    // all four held, then direction switch mid-DELAY
    push(0, 10, 10, 0);
    ld(0, 10, 10, 0, 4'b0000);
    push(0, 9, 9, 0);
    tk(0, 4'b1111);
    tk(0, 4'b0000);
    push(0, 8, 9, 0);
    tk(0, 4'b1000);
    tk(0, 4'b1000);
    push(0, 8, 10, 0);
    tk(0, 4'b0001);
    for (int t = 0; t < 7; t++) tk(0, 4'b0001);
    push(0, 8, 11, 0);
    tk(0, 4'b0001);
    tk(0, 4'b0000);

    // acceleration: hold right for 29 ticks from (100,100)
    push(0, 100, 100, 0);
    ld(0, 100, 100, 0, 4'b0000);
    ax = 100; rep = 0; f = 1'b0;
    for (int t = 0; t <= 28; t++) begin
      mv = (t == 0) || (t == 8) || (t > 8 && (t % 2) == 0);
      if (mv) begin
        ax += f ? 4 : 1;
        if (t > 8) begin
          rep++;
`ifdef CURSOR_ACCEL_EN
          if (rep == 8) f = 1'b1;
`endif
        end
        push(0, ax, 100, f);
      end
      tk(0, 4'b0010);
    end
`ifdef CURSOR_ACCEL_EN
    chk("accel_end_x", int'(if0.x), 118);
`else
    chk("accel_end_x", int'(if0.x), 112);
`endif
    tk(0, 4'b0000);
    chk("release_fast", int'(if0.fast), 0);
    ax++;
    push(0, ax, 100, 0);
    tk(0, 4'b0010);
    tk(0, 4'b0000);

    // load beats tick; state forced to IDLE so next same-direction tick moves
    ax--;
    push(0, ax, 100, 0);
    tk(0, 4'b1000);
    push(0, 319, 50, 0);
    ld(0, 400, 50, 1, 4'b1000);
    push(0, 318, 50, 0);
    tk(0, 4'b1000);
    tk(0, 4'b0000);

    // wrap instance
    push(1, 0, 0, 0);
    ld(1, 0, 0, 0, 4'b0000);
    push(1, 319, 239, 0);
    tk(1, 4'b1100);
    tk(1, 4'b0000);
    push(1, 0, 239, 0);
    tk(1, 4'b0010);
    tk(1, 4'b0000);

    // reset wins over load and tick
    @(negedge clock);
    reset = 1'b1;
    if0.load = 1'b1; if0.load_x = 9'd5; if0.load_y = 9'd5;
    if0.tick = 1'b1; if0.directions = 4'b1000;
    @(negedge clock);
    reset = 1'b0;
    if0.load = 1'b0; if0.tick = 1'b0; if0.directions = 4'b0000;
    chk("reset_load_x", int'(if0.x), 160);
    chk("reset_load_y", int'(if0.y), 120);
    chk("reset_load_moved", int'(if0.moved), 0);

    repeat (3) @(negedge clock);
    chk("dut0_missing_moves", q0.size(), 0);
    chk("dut1_missing_moves", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
